// File: rtl/fft_input_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fft_input_buffer: ping-pong frame buffer feeding a zero-padded FFT stream |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module fft_input_buffer #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int NUM_SAMPLES  = 400,
   parameter int NFFT_SIZE    = 512,
   parameter bit BIT_REVERSE  = 1'b0
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid_i,
   input  logic [$clog2(NFFT_SIZE)-1:0]  frame_ptr_i,
   input  logic [SAMPLE_WIDTH-1:0]       sample_i,
   input  logic                          frame_done_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [SAMPLE_WIDTH-1:0]       out_real_o,
   output logic [SAMPLE_WIDTH-1:0]       out_imag_o,
   output logic [$clog2(NFFT_SIZE)-1:0]  out_index_o,
   output logic                          out_last_o,
   output logic                          busy_o,
   output logic [7:0]                    drop_count_o
);

   localparam int             AW     = $clog2(NFFT_SIZE);
   localparam logic [AW:0]    NS_LIM = (AW+1)'(NUM_SAMPLES);
   localparam logic [AW-1:0]  K_LAST = AW'(NFFT_SIZE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      STREAM = 2'd2
   } state_t;

   logic [SAMPLE_WIDTH-1:0] mem [0:1][0:NFFT_SIZE-1];

   state_t                  state;
   state_t                  state_next;
   logic                    wr_bank;
   logic [AW-1:0]           k;
   logic [AW-1:0]           rd_ptr;
   logic [AW-1:0]           word_idx;
   logic [AW-1:0]           idx_q;
   logic                    last_q;
   logic                    pad_q;
   logic [SAMPLE_WIDTH-1:0] rd_data;
   logic [7:0]              drops;
   logic                    xfer;
   logic                    last_xfer;
   logic                    accept;
   logic                    drop;
   logic                    load;
   logic                    wr_en;

   assign out_valid_o = (state == STREAM);
   assign busy_o      = (state != IDLE);
   assign xfer        = out_valid_o & out_ready_i;
   assign last_xfer   = xfer & last_q;
   // A frame finishing on the final transfer frees the read bank that same cycle.
   assign accept      = frame_done_i & (~busy_o | last_xfer);
   assign drop        = frame_done_i & busy_o & ~last_xfer;
   assign wr_en       = in_valid_i & ({1'b0, frame_ptr_i} < NS_LIM);
   assign rd_ptr      = (state == PRIME) ? '0 : k;

   generate
      if (BIT_REVERSE) begin : g_bitrev
         always_comb begin
            word_idx = '0;
            for (int i = 0; i < AW; i++) begin
               word_idx[i] = rd_ptr[AW-1-i];
            end
         end
      end else begin : g_natural
         assign word_idx = rd_ptr;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = PRIME;
            end
         end
         PRIME: begin
            load       = 1'b1;
            state_next = STREAM;
         end
         STREAM: begin
            if (xfer) begin
               if (last_q) begin
                  state_next = accept ? PRIME : IDLE;
               end else begin
                  load = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank <= 1'b0;
         k       <= '0;
         idx_q   <= '0;
         last_q  <= 1'b0;
         pad_q   <= 1'b0;
         drops   <= 8'd0;
      end else begin
         if (accept) begin
            wr_bank <= ~wr_bank;
         end
         if (drop && (drops != 8'hFF)) begin
            drops <= drops + 8'd1;
         end
         if (load) begin
            idx_q  <= word_idx;
            last_q <= (rd_ptr == K_LAST);
            pad_q  <= ({1'b0, word_idx} >= NS_LIM);
            k      <= rd_ptr + AW'(1);
         end
      end
   end

   // Storage is left unreset so it can map onto block RAM with a registered read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_bank][frame_ptr_i] <= sample_i;
      end
      if (load) begin
         rd_data <= mem[~wr_bank][word_idx];
      end
   end

   assign out_real_o   = (out_valid_o && !pad_q) ? rd_data : '0;
   assign out_imag_o   = '0;
   assign out_index_o  = idx_q;
   assign out_last_o   = out_valid_o & last_q;
   assign drop_count_o = drops;

endmodule
`default_nettype wire

// File: doc/fft_input_buffer.md
FFT_INPUT_BUFFER -- requirements
Module: fft_input_buffer

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16, sample width in bits (signed two's complement).
REQ-002 SHALL have parameter NUM_SAMPLES, default 400, number of windowed samples per frame.
REQ-003 SHALL have parameter NFFT_SIZE, default 512, FFT length; power of two, at least NUM_SAMPLES.
REQ-004 SHALL have parameter BIT_REVERSE, default 0; when 1, samples stream in bit-reversed index order.
REQ-005 SHALL have one clock and an asynchronous active-low reset, with ports in this order:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid_i  input  1  sample strobe from hamming_window out_valid_o.
- frame_ptr_i  input  log2(NFFT_SIZE)  sample index within the frame.
- sample_i  input  SAMPLE_WIDTH  windowed sample.
- frame_done_i  input  1  one-cycle pulse marking the end of the frame.
- out_valid_o  output  1  stream data valid.
- out_ready_i  input  1  FFT consumer ready.
- out_real_o  output  SAMPLE_WIDTH  real part.
- out_imag_o  output  SAMPLE_WIDTH  imaginary part; always 0.
- out_index_o  output  log2(NFFT_SIZE)  natural-order bin index of the current word.
- out_last_o  output  1  high on the final word of the frame.
- busy_o  output  1  read bank holds an unsent or partially sent frame.
- drop_count_o  output  8  number of dropped frames; saturates at 255.

Function
REQ-006 SHALL contain two NFFT_SIZE x SAMPLE_WIDTH banks: one write bank and one read bank (ping-pong).
REQ-007 Write: on in_valid_i with frame_ptr_i < NUM_SAMPLES, the block SHALL store sample_i at address frame_ptr_i of the write bank.
REQ-008 Write: when frame_ptr_i >= NUM_SAMPLES, the block SHALL ignore the sample.
REQ-009 Frame done with read bank free (busy_o=0): the block SHALL swap banks and set busy_o on the next edge.
REQ-010 Frame done with busy_o=1: the block SHALL drop the frame, increment drop_count_o, and keep writing into the same write bank.
REQ-011 When in_valid_i and frame_done_i are high in the same cycle, the sample SHALL be written before the swap.
REQ-012 Read FSM SHALL have states IDLE, PRIME and STREAM.
REQ-013 IDLE -> PRIME on swap; PRIME performs the first memory read; PRIME -> STREAM with out_valid_o=1.
REQ-014 First out_valid_o SHALL assert exactly 2 cycles after the frame_done_i edge.
REQ-015 Handshake: a word transfers when out_valid_o and out_ready_i are both high.
REQ-016 While out_valid_o=1 and out_ready_i=0, out_real_o, out_index_o and out_last_o SHALL hold stable.
REQ-017 Throughput SHALL be one word per cycle while out_ready_i stays high; the read address is prefetched.
REQ-018 The stream SHALL have NFFT_SIZE words, counter k = 0..NFFT_SIZE-1.
REQ-019 out_index_o SHALL equal k when BIT_REVERSE=0, and bitrev(k) when BIT_REVERSE=1.
REQ-020 out_real_o SHALL be 0 when out_index_o >= NUM_SAMPLES (zero padding), regardless of bank contents.
REQ-021 Otherwise out_real_o SHALL be the stored sample at that index.
REQ-022 out_last_o SHALL be high only when k = NFFT_SIZE-1.
REQ-023 When the last word transfers, the FSM SHALL go to IDLE and clear busy_o.
REQ-024 If frame_done_i arrives in the same cycle as the last transfer, the frame SHALL be accepted, not dropped, and the FSM goes straight to PRIME.
REQ-025 Writes to the write bank SHALL proceed during streaming with no interaction with the read bank.

Reset
REQ-026 While rst_n=0, these outputs SHALL be 0: out_valid_o, out_last_o, busy_o, out_real_o, out_imag_o, out_index_o, drop_count_o.
REQ-027 While rst_n=0, the FSM SHALL be in IDLE, the write bank SHALL be bank 0, and k SHALL be 0.
REQ-028 Memory contents are not reset.
REQ-029 Reset during STREAM SHALL abort the frame; the first post-reset frame_done_i streams normally.

Verification
REQ-030 Ramp test: write sample_i = ptr+1 for ptr 0..399, pulse frame_done_i, hold out_ready_i=1.
- Required: 512 words, out_real_o = 1..400, then 112 zeros.
- Required: out_last_o only at index 511; first valid 2 cycles after done; busy_o low after the last transfer.
REQ-031 Backpressure test: toggle out_ready_i randomly.
- Required: no word lost or duplicated; outputs stable while stalled; same 512-word sequence as REQ-030.
REQ-032 Overlap test: send frame B of value -5 while frame A streams; B's done arrives after A's last transfer.
- Required: A intact, then B streams all -5 for 0..399; drop_count_o = 0.
REQ-033 Drop test: with out_ready_i=0 and busy_o=1, pulse frame_done_i twice.
- Required: drop_count_o = 2; stalled frame data unchanged.
REQ-034 Bit-reverse test: BIT_REVERSE=1, NFFT_SIZE=512, ramp input.
- Required: word k has out_index_o = bitrev9(k); out_real_o = index+1 when index < 400, else 0.
REQ-035 Reset test: assert rst_n=0 at word 200.
- Required: outputs 0 at once; the next frame streams complete from index 0.
